// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready register slice: mode selectors and
// the state encoding of the two-entry (full) slice.
package hs_pkg;

    localparam int HS_MODE_BYPASS = 0;
    localparam int HS_MODE_FWD    = 1;
    localparam int HS_MODE_BWD    = 2;
    localparam int HS_MODE_FULL   = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/hs_skid_buf.sv
// Single-entry skid register: a valid flag plus a payload word. Load has
// priority over drain; the payload is only meaningful while vld is set.
module hs_skid_buf
    import hs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] d,
    output logic              vld,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hs_reg_slice.sv
// Valid/ready register slice for one point-to-point channel: bypass, forward
// register, backward (skid) register or fully registered two-entry buffer.
module hs_reg_slice
    import hs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MODE   = HS_MODE_FULL,
    parameter int CNT_W  = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  beat_cnt
);

    generate
        if (MODE == HS_MODE_BYPASS) begin : g_bypass
            assign m_valid = s_valid;
            assign m_data  = s_data;
            assign s_ready = m_ready;
        end else if (MODE == HS_MODE_FWD) begin : g_fwd
            logic              live;
            logic              vld_p1;
            logic [DATA_W-1:0] data_p1;

            // live keeps s_ready low until the first edge after reset release
            assign s_ready = live && (!vld_p1 || m_ready);
            assign m_valid = vld_p1;
            assign m_data  = data_p1;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    live    <= 1'b0;
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    live <= 1'b1;
                    if (s_ready) begin
                        vld_p1 <= s_valid;
                        if (s_valid) begin
                            data_p1 <= s_data;
                        end
                    end
                end
            end
        end else if (MODE == HS_MODE_BWD) begin : g_bwd
            logic              rdy_p1;
            logic              skid_vld;
            logic              skid_load;
            logic              skid_vld_nxt;
            logic [DATA_W-1:0] skid_data;

            assign skid_load    = s_valid && rdy_p1 && !m_ready;
            assign skid_vld_nxt = skid_load || (skid_vld && !m_ready);

            hs_skid_buf #(.DATA_W(DATA_W)) u_skid (
                .clk   (sys_clk),
                .rst   (sys_rst),
                .load  (skid_load),
                .drain (m_ready),
                .d     (s_data),
                .vld   (skid_vld),
                .q     (skid_data)
            );

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    rdy_p1 <= 1'b0;
                end else begin
                    rdy_p1 <= !skid_vld_nxt;
                end
            end

            // Gating the pass-through with rdy_p1 keeps the output quiet while
            // the slice is still refusing beats after reset.
            assign s_ready = rdy_p1;
            assign m_valid = skid_vld || (s_valid && rdy_p1);
            assign m_data  = skid_vld ? skid_data : (rdy_p1 ? s_data : '0);
        end else begin : g_full
            buf_state_t        state;
            buf_state_t        state_nxt;
            logic              rdy_p1;
            logic [DATA_W-1:0] data_p1;
            logic              in_fire;
            logic              out_load;
            logic              out_from_skid;
            logic              skid_load;
            logic              skid_drain;
            logic              skid_vld;
            logic [DATA_W-1:0] skid_data;

            assign in_fire = s_valid && rdy_p1;

            always_comb begin
                state_nxt     = state;
                out_load      = 1'b0;
                out_from_skid = 1'b0;
                skid_load     = 1'b0;
                skid_drain    = 1'b0;
                case (state)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            state_nxt = ST_ONE;
                            out_load  = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && m_ready) begin
                            out_load = 1'b1;
                        end else if (in_fire) begin
                            state_nxt = ST_FULL;
                            skid_load = 1'b1;
                        end else if (m_ready) begin
                            state_nxt = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (m_ready) begin
                            state_nxt     = ST_ONE;
                            out_load      = 1'b1;
                            out_from_skid = 1'b1;
                            skid_drain    = 1'b1;
                        end
                    end
                    default: state_nxt = ST_EMPTY;
                endcase
            end

            hs_skid_buf #(.DATA_W(DATA_W)) u_skid (
                .clk   (sys_clk),
                .rst   (sys_rst),
                .load  (skid_load),
                .drain (skid_drain),
                .d     (s_data),
                .vld   (skid_vld),
                .q     (skid_data)
            );

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    state   <= ST_EMPTY;
                    rdy_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    state  <= state_nxt;
                    rdy_p1 <= (state_nxt != ST_FULL);
                    if (out_load) begin
                        data_p1 <= out_from_skid ? skid_data : s_data;
                    end
                end
            end

            assign s_ready = rdy_p1;
            assign m_valid = (state != ST_EMPTY);
            assign m_data  = data_p1;
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            beat_cnt <= '0;
        end else if (m_valid && m_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule
